// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive stages.
// Build option UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_STOP     = 3'd3,
    S_ACK_WAIT = 3'd4
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY   = 3'd5
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick pulses on the last clock of each serial bit.
// The count is held at zero whenever run is low so every bit starts aligned.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = run && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, 8 data bits LSB first, optional even parity
// (build option UART_TX_PARITY_EN), STOP_BITS stop bits, REQ/ACK handshake.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       XMIT_REQ,
  input  logic [7:0] XMIT_DATA,
  output logic       XMIT_ACK,
  output logic       TX_BUSY,
  output logic       TX
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        run;
  logic        bit_tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign run      = (state_q != S_IDLE) && (state_q != S_ACK_WAIT);
  assign TX       = tx_q;
  assign XMIT_ACK = ack_q;
  assign TX_BUSY  = busy_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .bit_tick (bit_tick)
  );

  // Each transition registers the level of the *next* bit, so TX only ever
  // changes on a bit boundary and comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = LINE_IDLE;
        if (XMIT_REQ) begin
          shift_d  = XMIT_DATA;
`ifdef UART_TX_PARITY_EN
          parity_d = ^XMIT_DATA;
`endif
          tx_d     = START_LEVEL;
          busy_d   = 1'b1;
          idx_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          tx_d    = LINE_IDLE;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = LINE_IDLE;
        if (bit_tick) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            idx_d   = '0;
            ack_d   = 1'b1;
            state_d = S_ACK_WAIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_ACK_WAIT: begin
        tx_d = LINE_IDLE;
        if (!XMIT_REQ) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= LINE_IDLE;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape, bit lengths, handshake,
// reset mid-frame and (with UART_TX_PARITY_EN) the parity bit.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int CPB       = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int NBITS     = 10 + PAR_BITS + STOP_BITS - 1;
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       xmit_req = 1'b0;
  logic [7:0] xmit_data = 8'h00;
  logic       xmit_ack;
  logic       tx_busy;
  logic       tx;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       samp [0:FRAME_CYC-1];
  logic [7:0] rx_byte;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .XMIT_REQ  (xmit_req),
    .XMIT_DATA (xmit_data),
    .XMIT_ACK  (xmit_ack),
    .TX_BUSY   (tx_busy),
    .TX        (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for frame bit b of byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR_BITS == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge back in idle.
  task automatic send_frame(input logic [7:0] data, input int drop_cyc,
                            input int glitch_cyc, input int hold_cyc);
    int hits;
    xmit_data = data;
    xmit_req  = 1'b1;
    @(posedge clk);
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      samp[c] = tx;
      if (c == 0) check("busy_start", 32'(tx_busy), 32'd1);
      if (c == FRAME_CYC - 1) check("ack_early", 32'(xmit_ack), 32'd0);
      if (c == drop_cyc) xmit_req = 1'b0;
      if (c == glitch_cyc) xmit_data = 8'hFF;
    end
    for (int b = 0; b < NBITS; b++) begin
      hits = 0;
      for (int k = 0; k < CPB; k++) begin
        if (samp[b*CPB + k] === exp_bit(data, b)) hits++;
      end
      check($sformatf("bit%0d_len_%02h", b, data), 32'(hits), 32'(CPB));
    end
    for (int i = 0; i < 8; i++) rx_byte[i] = samp[(i+1)*CPB + CPB/2];
    check("rx_byte", 32'(rx_byte), 32'(data));
    @(negedge clk);
    check("ack_rise", 32'(xmit_ack), 32'd1);
    check("tx_ack_idle", 32'(tx), 32'd1);
    check("busy_ack", 32'(tx_busy), 32'd1);
    for (int h = 0; h < hold_cyc; h++) begin
      @(negedge clk);
      check("ack_hold", 32'(xmit_ack), 32'd1);
      check("tx_hold", 32'(tx), 32'd1);
    end
    xmit_req = 1'b0;
    @(negedge clk);
    check("ack_fall", 32'(xmit_ack), 32'd0);
    check("busy_fall", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ack", 32'(xmit_ack), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);

    send_frame(8'hA5, -1, -1, 0);
    send_frame(8'h3C, -1, 20, 0);
    send_frame(8'h00, -1, -1, 0);
    send_frame(8'hFF, -1, -1, 0);
    send_frame(8'h5A, 26, -1, 0);
    send_frame(8'hC3, -1, -1, 5);

    // Reset while DATA bit 3 (value 0 for 0x96) is on the line.
    xmit_data = 8'h96;
    xmit_req  = 1'b1;
    @(posedge clk);
    repeat (35) @(negedge clk);
    check("mid_bit3", 32'(tx), 32'd0);
    clr      = 1'b0;
    xmit_req = 1'b0;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_ack", 32'(xmit_ack), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    send_frame(8'h55, -1, -1, 0);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, -1, -1, 0);
    check("par_07", 32'(samp[9*CPB + CPB/2]), 32'd1);
    send_frame(8'h03, -1, -1, 0);
    check("par_03", 32'(samp[9*CPB + CPB/2]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
